// File: rtl/cpu_common_pkg.sv
// Shared CPU types: stack request opcodes, SP adjustment codes and stack limits.
package cpu_common;

  typedef enum logic {
    STACK_PUSH = 1'b0,
    STACK_POP  = 1'b1
  } stack_op_t;

  typedef enum logic [2:0] {
    SP_NOP   = 3'd0,
    SP_INC_1 = 3'd1,
    SP_INC_2 = 3'd2,
    SP_DEC_1 = 3'd3,
    SP_DEC_2 = 3'd4
  } sp_operation_t;

  localparam int unsigned  SP_ADDR_W = 14;
  localparam logic [13:0]  SP_EMPTY  = 14'h3FFF;

  // Room check for a request against the current SP (next free byte, grows down).
  function automatic logic stack_bounds_ok(stack_op_t op, logic word, logic [13:0] sp);
    if (op == STACK_PUSH) return word ? (sp >= 14'd2) : (sp >= 14'd1);
    return word ? (sp <= 14'h3FFD) : (sp <= 14'h3FFE);
  endfunction

endpackage

// File: rtl/stack_ctrl.sv
// Push/pop sequencer: bounds-checks a request, runs the byte-wide memory
// accesses and issues the matching single-cycle SP adjustment.
module stack_ctrl
  import cpu_common::*;
(
  input  logic          clk,
  input  logic          rst_async,
  input  logic          req_valid,
  output logic          req_ready,
  input  stack_op_t     req_op,
  input  logic          req_word,
  input  logic [15:0]   req_wdata,
  output logic          rsp_valid,
  output logic          rsp_err,
  output logic [15:0]   rsp_rdata,
  input  logic [13:0]   sp_addr,
  output sp_operation_t sp_operation,
  output logic [13:0]   mem_addr,
  output logic          mem_we,
  output logic          mem_re,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_HI   = 3'd1,
    WR_LO   = 3'd2,
    RD_LO   = 3'd3,
    RD_HI   = 3'd4,
    RD_WAIT = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t      state_q, state_d;
  stack_op_t   op_q;
  logic        word_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        accept;

  assign accept = (state_q == IDLE) && req_valid;

  // State, latched request and response registers.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q <= IDLE;
      op_q    <= STACK_PUSH;
      word_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        op_q    <= req_op;
        word_q  <= req_word;
        wdata_q <= req_wdata;
      end
    end
  end

  // Next state, read-data capture and per-state decode of memory/SP outputs.
  always_comb begin
    state_d      = state_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    mem_addr     = '0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    mem_wdata    = '0;
    sp_operation = SP_NOP;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          // Pushes and errors report zero data, so clear it up front.
          rdata_d = '0;
          if (stack_bounds_ok(req_op, req_word, sp_addr)) begin
            err_d = 1'b0;
            if (req_op == STACK_PUSH) state_d = req_word ? WR_HI : WR_LO;
            else                      state_d = RD_LO;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      WR_HI: begin
        mem_addr  = sp_addr;
        mem_wdata = wdata_q[15:8];
        mem_we    = 1'b1;
        state_d   = WR_LO;
      end
      WR_LO: begin
        // SP hasn't moved after WR_HI, so the low byte of a word sits at sp-1.
        mem_addr     = word_q ? (sp_addr - 14'd1) : sp_addr;
        mem_wdata    = wdata_q[7:0];
        mem_we       = 1'b1;
        sp_operation = word_q ? SP_DEC_2 : SP_DEC_1;
        state_d      = DONE;
      end
      RD_LO: begin
        mem_addr = sp_addr + 14'd1;
        mem_re   = 1'b1;
        state_d  = word_q ? RD_HI : RD_WAIT;
      end
      RD_HI: begin
        mem_addr      = sp_addr + 14'd2;
        mem_re        = 1'b1;
        rdata_d[7:0]  = mem_rdata;
        state_d       = RD_WAIT;
      end
      RD_WAIT: begin
        if (word_q) rdata_d[15:8] = mem_rdata;
        else        rdata_d       = {8'h00, mem_rdata};
        sp_operation = word_q ? SP_INC_2 : SP_INC_1;
        state_d      = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_err   = (state_q == DONE) && err_q;
  assign rsp_rdata = rdata_q;

  logic unused_op;
  assign unused_op = (op_q == STACK_POP);

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl with a stack pointer block model and a sync-read byte RAM.
module tb_stack_ctrl;
  import cpu_common::*;

  logic          clk = 1'b0;
  logic          rst_async = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  stack_op_t     req_op = STACK_PUSH;
  logic          req_word = 1'b0;
  logic [15:0]   req_wdata = '0;
  logic          rsp_valid, rsp_err;
  logic [15:0]   rsp_rdata;
  logic [13:0]   sp_addr;
  sp_operation_t sp_operation;
  logic [13:0]   mem_addr;
  logic          mem_we, mem_re;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stack_ctrl dut (
    .clk(clk), .rst_async(rst_async),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_word(req_word), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .sp_addr(sp_addr), .sp_operation(sp_operation),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Stack pointer block model.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) sp_addr <= SP_EMPTY;
    else begin
      case (sp_operation)
        SP_INC_1: sp_addr <= sp_addr + 14'd1;
        SP_INC_2: sp_addr <= sp_addr + 14'd2;
        SP_DEC_1: sp_addr <= sp_addr - 14'd1;
        SP_DEC_2: sp_addr <= sp_addr - 14'd2;
        default:  sp_addr <= sp_addr;
      endcase
    end
  end

  // 16 KiB sync-read byte RAM.
  logic [7:0] ram [0:16383];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  // Activity counters sampled on the active edge.
  int we_cnt = 0, re_cnt = 0, spop_cnt = 0, rsp_cnt = 0, acc_cnt = 0;
  always @(posedge clk) begin
    if (!rst_async) begin
      if (mem_we) we_cnt++;
      if (mem_re) re_cnt++;
      if (sp_operation != SP_NOP) spop_cnt++;
      if (rsp_valid) rsp_cnt++;
      if (req_valid && req_ready) acc_cnt++;
    end
  end

  // Issue one request and wait for its response; lat counts cycles after acceptance (-1 on timeout).
  task automatic do_req(input stack_op_t op, input logic word, input logic [15:0] wd,
                        output int lat, output logic err, output logic [15:0] rd);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_op = op; req_word = word; req_wdata = wd;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
    err = rsp_err; rd = rsp_rdata;
    if (!rsp_valid) lat = -1;
  endtask

  task automatic test_reset;
    rst_async = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    checks++; if ({rsp_valid, rsp_err, mem_we, mem_re} !== 4'b0) begin failures++; $display("FAIL reset_strobes: got %b want 0000", {rsp_valid, rsp_err, mem_we, mem_re}); end
    checks++; if ({rsp_rdata, mem_addr, mem_wdata} !== 38'h0) begin failures++; $display("FAIL reset_data: got %h want 0", {rsp_rdata, mem_addr, mem_wdata}); end
    checks++; if (sp_operation !== SP_NOP) begin failures++; $display("FAIL reset_spop: got %0d want SP_NOP", sp_operation); end
    rst_async = 1'b0;
    @(negedge clk);
    checks++; if (sp_addr !== 14'h3FFF) begin failures++; $display("FAIL reset_sp: got %h want 3fff", sp_addr); end
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_release: ready=%b valid=%b want 1/0", req_ready, rsp_valid); end
  endtask

  task automatic test_word;
    int lat; logic err; logic [15:0] rd; int we0, re0;
    we0 = we_cnt; re0 = re_cnt;
    do_req(STACK_PUSH, 1'b1, 16'hBEEF, lat, err, rd);
    checks++; if (lat !== 3 || err !== 1'b0) begin failures++; $display("FAIL wpush_lat: got lat=%0d err=%b want 3/0", lat, err); end
    checks++; if (ram[14'h3FFF] !== 8'hBE || ram[14'h3FFE] !== 8'hEF) begin failures++; $display("FAIL wpush_mem: got %h %h want be ef", ram[14'h3FFF], ram[14'h3FFE]); end
    checks++; if (sp_addr !== 14'h3FFD) begin failures++; $display("FAIL wpush_sp: got %h want 3ffd", sp_addr); end
    checks++; if (we_cnt - we0 !== 2) begin failures++; $display("FAIL wpush_we: got %0d want 2", we_cnt - we0); end
    do_req(STACK_POP, 1'b1, 16'h0, lat, err, rd);
    checks++; if (lat !== 4 || err !== 1'b0) begin failures++; $display("FAIL wpop_lat: got lat=%0d err=%b want 4/0", lat, err); end
    checks++; if (rd !== 16'hBEEF) begin failures++; $display("FAIL wpop_data: got %h want beef", rd); end
    checks++; if (sp_addr !== 14'h3FFF) begin failures++; $display("FAIL wpop_sp: got %h want 3fff", sp_addr); end
    checks++; if (re_cnt - re0 !== 2) begin failures++; $display("FAIL wpop_re: got %0d want 2", re_cnt - re0); end
  endtask

  task automatic test_bytes;
    int lat; logic err; logic [15:0] rd;
    do_req(STACK_PUSH, 1'b0, 16'hFF5A, lat, err, rd);
    checks++; if (lat !== 2 || err !== 1'b0 || rd !== 16'h0) begin failures++; $display("FAIL bpush_lat: got lat=%0d err=%b rd=%h want 2/0/0", lat, err, rd); end
    do_req(STACK_PUSH, 1'b0, 16'h77C3, lat, err, rd);
    checks++; if (sp_addr !== 14'h3FFD) begin failures++; $display("FAIL bpush_sp: got %h want 3ffd", sp_addr); end
    checks++; if (ram[14'h3FFF] !== 8'h5A || ram[14'h3FFE] !== 8'hC3) begin failures++; $display("FAIL bpush_mem: got %h %h want 5a c3", ram[14'h3FFF], ram[14'h3FFE]); end
    do_req(STACK_POP, 1'b0, 16'h0, lat, err, rd);
    checks++; if (lat !== 3 || rd !== 16'h00C3) begin failures++; $display("FAIL bpop1: got lat=%0d rd=%h want 3/00c3", lat, rd); end
    do_req(STACK_POP, 1'b0, 16'h0, lat, err, rd);
    checks++; if (rd !== 16'h005A || err !== 1'b0) begin failures++; $display("FAIL bpop2: got rd=%h err=%b want 005a/0", rd, err); end
    checks++; if (sp_addr !== 14'h3FFF) begin failures++; $display("FAIL bpop_sp: got %h want 3fff", sp_addr); end
  endtask

  task automatic test_underflow;
    int lat; logic err; logic [15:0] rd; int re0, sp0;
    re0 = re_cnt; sp0 = spop_cnt;
    do_req(STACK_POP, 1'b0, 16'h0, lat, err, rd);
    checks++; if (lat !== 1 || err !== 1'b1 || rd !== 16'h0) begin failures++; $display("FAIL uflow_byte: got lat=%0d err=%b rd=%h want 1/1/0", lat, err, rd); end
    checks++; if (re_cnt - re0 !== 0 || spop_cnt - sp0 !== 0) begin failures++; $display("FAIL uflow_side: got re=%0d spop=%0d want 0/0", re_cnt - re0, spop_cnt - sp0); end
    checks++; if (sp_addr !== 14'h3FFF) begin failures++; $display("FAIL uflow_sp: got %h want 3fff", sp_addr); end
    do_req(STACK_PUSH, 1'b0, 16'h0042, lat, err, rd);
    do_req(STACK_POP, 1'b1, 16'h0, lat, err, rd);
    checks++; if (lat !== 1 || err !== 1'b1 || sp_addr !== 14'h3FFE) begin failures++; $display("FAIL uflow_word: got lat=%0d err=%b sp=%h want 1/1/3ffe", lat, err, sp_addr); end
    do_req(STACK_POP, 1'b0, 16'h0, lat, err, rd);
    checks++; if (err !== 1'b0 || rd !== 16'h0042 || sp_addr !== 14'h3FFF) begin failures++; $display("FAIL uflow_recover: got err=%b rd=%h sp=%h want 0/0042/3fff", err, rd, sp_addr); end
  endtask

  task automatic test_back_to_back;
    stack_op_t   ops [4]  = '{STACK_PUSH, STACK_PUSH, STACK_POP, STACK_POP};
    logic [15:0] wds [4]  = '{16'h0011, 16'h0022, 16'h0000, 16'h0000};
    logic [15:0] exp [4]  = '{16'h0000, 16'h0000, 16'h0022, 16'h0011};
    int acc0, n, lat;
    acc0 = acc_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_word = 1'b0; req_op = ops[0]; req_wdata = wds[0];
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      checks++; if (n !== (i == 0 ? 0 : 1)) begin failures++; $display("FAIL b2b_gap%0d: got %0d idle-wait cycles want %0d", i, n, (i == 0 ? 0 : 1)); end
      lat = 0;
      do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
      checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== exp[i]) begin failures++; $display("FAIL b2b_rsp%0d: got v=%b e=%b rd=%h want 1/0/%h", i, rsp_valid, rsp_err, rsp_rdata, exp[i]); end
      if (i < 3) begin req_op = ops[i+1]; req_wdata = wds[i+1]; end
      else req_valid = 1'b0;
    end
    repeat (2) @(negedge clk);
    checks++; if (acc_cnt - acc0 !== 4) begin failures++; $display("FAIL b2b_accepts: got %0d want 4", acc_cnt - acc0); end
    checks++; if (sp_addr !== 14'h3FFF) begin failures++; $display("FAIL b2b_sp: got %h want 3fff", sp_addr); end
  endtask

  task automatic test_reset_mid;
    int lat; logic err; logic [15:0] rd; int r0;
    do_req(STACK_PUSH, 1'b1, 16'h1234, lat, err, rd);
    @(negedge clk);
    req_valid = 1'b1; req_op = STACK_POP; req_word = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    checks++; if (mem_re !== 1'b1 || mem_addr !== 14'h3FFE) begin failures++; $display("FAIL mid_rdlo: got re=%b addr=%h want 1/3ffe", mem_re, mem_addr); end
    @(negedge clk);
    checks++; if (mem_re !== 1'b1 || mem_addr !== 14'h3FFF) begin failures++; $display("FAIL mid_rdhi: got re=%b addr=%h want 1/3fff", mem_re, mem_addr); end
    r0 = rsp_cnt;
    rst_async = 1'b1;
    #1;
    checks++; if ({req_ready, rsp_valid, mem_re, mem_we} !== 4'b1000 || mem_addr !== 14'h0 || sp_operation !== SP_NOP) begin failures++; $display("FAIL mid_abort: got rdy/v/re/we=%b addr=%h spop=%0d want 1000/0/NOP", {req_ready, rsp_valid, mem_re, mem_we}, mem_addr, sp_operation); end
    @(negedge clk);
    rst_async = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rsp_cnt - r0 !== 0 || req_ready !== 1'b1 || sp_addr !== 14'h3FFF) begin failures++; $display("FAIL mid_after: got rsps=%0d ready=%b sp=%h want 0/1/3fff", rsp_cnt - r0, req_ready, sp_addr); end
  endtask

  task automatic test_overflow;
    int lat; logic err; logic [15:0] rd; int errs, guard, we0;
    errs = 0; guard = 0;
    while (sp_addr > 14'd1 && guard < 16400) begin
      do_req(STACK_PUSH, 1'b0, {2'b00, sp_addr}, lat, err, rd);
      if (err !== 1'b0 || lat !== 2) errs++;
      guard++;
    end
    checks++; if (sp_addr !== 14'd1 || errs !== 0) begin failures++; $display("FAIL oflow_fill: got sp=%h errs=%0d want 0001/0", sp_addr, errs); end
    checks++; if (ram[2] !== 8'h02) begin failures++; $display("FAIL oflow_mem2: got %h want 02", ram[2]); end
    we0 = we_cnt;
    do_req(STACK_PUSH, 1'b1, 16'hDEAD, lat, err, rd);
    checks++; if (lat !== 1 || err !== 1'b1 || sp_addr !== 14'd1 || we_cnt - we0 !== 0) begin failures++; $display("FAIL oflow_word: got lat=%0d err=%b sp=%h we=%0d want 1/1/0001/0", lat, err, sp_addr, we_cnt - we0); end
    do_req(STACK_PUSH, 1'b0, 16'h00AA, lat, err, rd);
    checks++; if (lat !== 2 || err !== 1'b0 || ram[1] !== 8'hAA || sp_addr !== 14'd0) begin failures++; $display("FAIL oflow_last: got lat=%0d err=%b mem=%h sp=%h want 2/0/aa/0000", lat, err, ram[1], sp_addr); end
    do_req(STACK_PUSH, 1'b0, 16'h00BB, lat, err, rd);
    checks++; if (lat !== 1 || err !== 1'b1 || sp_addr !== 14'd0 || ram[0] === 8'hBB) begin failures++; $display("FAIL oflow_full: got lat=%0d err=%b sp=%h mem0=%h want 1/1/0000/not-bb", lat, err, sp_addr, ram[0]); end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = 8'h00;
    test_reset;
    test_word;
    test_bytes;
    test_underflow;
    test_back_to_back;
    test_reset_mid;
    test_overflow;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Push/pop sequencer sitting directly upstream of the stack pointer block: it is the only driver of `sp_operation` and consumes the current `sp_addr`. It accepts byte or 16-bit push/pop requests from the cpu control unit, bounds-checks them against the stack limits, and runs the byte-wide memory accesses. It then commits the matching SP adjustment. The stack grows downward from 14'h3FFF, with `sp_addr` pointing at the next free byte.

## Interface
Parameters: none. Widths are fixed by the 14-bit address space.
- clk  in  1  clock
- rst_async  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when `req_valid && req_ready`
- req_op  in  stack_op_t  STACK_PUSH / STACK_POP
- req_word  in  1  1 = 16-bit, 0 = 8-bit
- req_wdata  in  16  push data (byte push uses [7:0])
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  qualifies rsp_valid: request rejected (overflow/underflow)
- rsp_rdata  out  16  pop data, zero-extended for byte pops; 0 for pushes and errors
- sp_addr  in  14  current stack pointer, from the stack pointer block
- sp_operation  out  sp_operation_t  SP adjustment for this cycle
- mem_addr  out  14  byte address
- mem_we  out  1  write strobe
- mem_re  out  1  read strobe; data appears on mem_rdata the next cycle
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte

## Operation
- States are IDLE, WR_HI, WR_LO, RD_LO, RD_HI, RD_WAIT and DONE.
- The request (op, word, wdata) is latched on acceptance.
- req_ready is 1 only in IDLE.
- Bounds check in IDLE, evaluated at acceptance:
  - byte push needs sp_addr ≥ 1
  - word push needs sp_addr ≥ 2
  - byte pop needs sp_addr ≤ 14'h3FFE
  - word pop needs sp_addr ≤ 14'h3FFD
  - On failure: go straight to DONE with rsp_err=1. No memory access; sp_operation stays SP_NOP.
- Byte push: IDLE → WR_LO (mem_addr=sp, mem_wdata=[7:0], mem_we, SP_DEC_1) → DONE.
- Word push: IDLE → WR_HI (mem_addr=sp, mem_wdata=[15:8], mem_we, SP_NOP) → WR_LO (mem_addr=sp−1, mem_wdata=[7:0], mem_we, SP_DEC_2) → DONE.
- Memory layout is little-endian: low byte at the lower address.
- Byte pop: IDLE → RD_LO (mem_re, mem_addr=sp+1) → RD_WAIT (capture mem_rdata into [7:0], clear [15:8], SP_INC_1) → DONE.
- Word pop: IDLE → RD_LO (mem_re, sp+1) → RD_HI (mem_re, sp+2, capture low byte) → RD_WAIT (capture high byte, SP_INC_2) → DONE.
- DONE: rsp_valid=1 and rsp_rdata is held stable; next state is IDLE. sp_addr already shows the updated value.
- Every SP adjustment is issued in exactly one cycle per request. All other cycles drive SP_NOP.
- Address arithmetic (sp±n) is 14-bit modular. The bounds check guarantees no wrap on accepted requests.

## Timing
- Reset values:
  - state = IDLE
  - req_ready = 1
  - rsp_valid, rsp_err, mem_we, mem_re = 0
  - rsp_rdata, mem_addr, mem_wdata = 0
  - sp_operation = SP_NOP
- The stack pointer block resets sp to 14'h3FFF concurrently.
- Latency, from acceptance edge T to the rsp_valid cycle:
  - byte push T+2
  - word push T+3
  - byte pop T+3
  - word pop T+4
  - error T+1
- The next request can be accepted in the cycle after DONE.
- Reset mid-operation: abort immediately and return to IDLE. A partial write already issued is not undone, and no response is produced.
- All outputs are registered or decoded from registered state only. They are combinational on sp_addr for mem_addr, but never on req_* inputs.

## Structure
- cpu_common holds:
  - `stack_op_t` (STACK_PUSH, STACK_POP)
  - existing `sp_operation_t` (SP_NOP, SP_INC_1, SP_INC_2, SP_DEC_1, SP_DEC_2)
  - constant `SP_EMPTY = 14'h3FFF`
- The state enum stays local to the module.
- No sub-module is needed. The bench instantiates stack_ctrl together with the stack pointer block and a 16 KiB sync-read byte RAM model.

## Test plan
- After reset, word push 16'hBEEF → writes mem[3FFF]=BE, mem[3FFE]=EF. sp becomes 3FFD; rsp_valid at T+3 with rsp_err=0.
- Then word pop → rsp_rdata=16'hBEEF at T+4, sp back to 3FFF.
- Byte push 8'h5A, byte push 8'hC3, then byte pop and byte pop → 16'h00C3 then 16'h005A; sp returns to 3FFF.
- Underflow on empty stack (sp=3FFF):
  - byte pop → rsp_valid at T+1 with rsp_err=1, rsp_rdata=0
  - no mem_re, sp_operation=SP_NOP throughout
- Overflow near the limit:
  - Drive sp to 1 with byte pushes, then word push → rsp_err=1, sp stays 1.
  - Byte push at sp=1 succeeds: mem[1] written, sp=0. A further byte push is then rejected.
- Assert rst_async during RD_HI of a word pop → outputs return to reset values the same cycle. No rsp_valid; sp=3FFF; req_ready=1 after release.
- req_valid held high across back-to-back requests → exactly one acceptance per IDLE cycle, and responses arrive in request order.
